// File: rtl/vdp_pkg.sv
// vdp_pkg
// Shared definitions for the VDP host port: command op codes, VDP host-bus
// mode encodings, VDP register indices and the state encodings of the two
// FSMs (bus phase sequencer and command sequencer).
package vdp_pkg;

   // Host command op codes (cmd_op)
   typedef enum logic [1:0] {
      OP_SET_REG    = 2'b00,
      OP_READ_REG   = 2'b01,
      OP_WRITE_VRAM = 2'b10,
      OP_READ_VRAM  = 2'b11
   } op_e;

   // VDP host-bus mode encodings (vdp_mode)
   localparam logic [1:0] MODE_SELECT = 2'b00;
   localparam logic [1:0] MODE_REG    = 2'b01;
   localparam logic [1:0] MODE_VRAM   = 2'b10;

   // VDP register indices
   localparam logic [3:0] REG_VRAM_WADDR_LO = 4'd0;
   localparam logic [3:0] REG_VRAM_WADDR_HI = 4'd1;
   localparam logic [3:0] REG_VRAM_RADDR_LO = 4'd2;
   localparam logic [3:0] REG_VRAM_RADDR_HI = 4'd3;
   localparam logic [3:0] REG_NAME_LO       = 4'd4;
   localparam logic [3:0] REG_NAME_HI       = 4'd5;
   localparam logic [3:0] REG_COLOUR_LO     = 4'd6;
   localparam logic [3:0] REG_COLOUR_HI     = 4'd7;
   localparam logic [3:0] REG_PATTERN_LO    = 4'd8;
   localparam logic [3:0] REG_PATTERN_HI    = 4'd9;

   // One bus phase: SETUP -> STROBE (n cycles) -> HOLD
   typedef enum logic [1:0] {
      PH_IDLE   = 2'b00,
      PH_SETUP  = 2'b01,
      PH_STROBE = 2'b10,
      PH_HOLD   = 2'b11
   } phase_state_e;

   // Command sequencer: bus phases in flight, then optional VRAM gap
   typedef enum logic [1:0] {
      HP_IDLE  = 2'b00,
      HP_PHASE = 2'b01,
      HP_GAP   = 2'b10
   } host_state_e;

   // Mode of the main (non-select) phase of a command
   function automatic logic [1:0] op_mode(input op_e op);
      return op[1] ? MODE_VRAM : MODE_REG;
   endfunction

   // Register commands may need a preceding select phase
   function automatic logic op_is_reg(input op_e op);
      return !op[1];
   endfunction

endpackage

// File: rtl/vdp_bus_phase.sv
// vdp_bus_phase
// Runs one VDP host-bus phase: SETUP (1 cycle, mode/data driven, strobes low)
// -> STROBE (STROBE_CYCLES cycles, one strobe high) -> HOLD (1 cycle, strobe
// low, mode/data unchanged). A new phase may start from IDLE or directly from
// HOLD so that two phases run back to back.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          begin a phase (honoured in IDLE or HOLD)
//   mode, wdata    mode and data for the phase, latched on start
//   is_read        1 = read strobe, 0 = write strobe, latched on start
//   state          current phase state (debug visibility)
//   done           high during the HOLD cycle
//   rd_valid       high during the HOLD cycle of a read phase
//   rdata          vdp_rdata captured on the last STROBE cycle of a read
//   vdp_*          VDP host bus
module vdp_bus_phase
   import vdp_pkg::*;
#(
   parameter int STROBE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [7:0]   wdata,
   input  logic         is_read,
   output phase_state_e state,
   output logic         done,
   output logic         rd_valid,
   output logic [7:0]   rdata,
   output logic [1:0]   vdp_mode,
   output logic         vdp_read,
   output logic         vdp_write,
   output logic [7:0]   vdp_wdata,
   input  logic [7:0]   vdp_rdata
);

   localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   phase_state_e state_nx;
   logic [CW-1:0] strobe_cnt;
   logic [1:0]    mode_q;
   logic [7:0]    wdata_q;
   logic          is_read_q;
   logic [7:0]    rdata_q;
   logic          can_start;
   logic          last_strobe;

   assign can_start   = (state == PH_IDLE) || (state == PH_HOLD);
   assign last_strobe = (state == PH_STROBE) && (strobe_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= PH_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         PH_IDLE:   if (start) state_nx = PH_SETUP;
         PH_SETUP:  state_nx = PH_STROBE;
         PH_STROBE: if (strobe_cnt == '0) state_nx = PH_HOLD;
         PH_HOLD:   state_nx = start ? PH_SETUP : PH_IDLE;
         default:   state_nx = PH_IDLE;
      endcase
   end

   // Phase datapath: latched mode/data, strobe length counter, read capture
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_cnt <= '0;
         mode_q     <= MODE_SELECT;
         wdata_q    <= 8'h00;
         is_read_q  <= 1'b0;
         rdata_q    <= 8'h00;
      end else begin
         if (start && can_start) begin
            mode_q    <= mode;
            wdata_q   <= wdata;
            is_read_q <= is_read;
         end
         if (state == PH_SETUP)
            strobe_cnt <= CW'(STROBE_CYCLES - 1);
         else if (state == PH_STROBE && strobe_cnt != '0)
            strobe_cnt <= strobe_cnt - 1'b1;
         if (last_strobe && is_read_q)
            rdata_q <= vdp_rdata;
      end
   end

   // Outputs: mode/data stay on the bus from SETUP through HOLD and beyond,
   // so the VDP sees stable values around the strobe falling edge.
   always_comb begin
      vdp_mode  = mode_q;
      vdp_wdata = wdata_q;
      vdp_read  = (state == PH_STROBE) &&  is_read_q;
      vdp_write = (state == PH_STROBE) && !is_read_q;
      done      = (state == PH_HOLD);
      rd_valid  = (state == PH_HOLD) && is_read_q;
      rdata     = rdata_q;
   end

endmodule

// File: rtl/vdp_host_port.sv
// vdp_host_port
// CPU-side bus initiator for the VDP register/VRAM port. Accepts commands on
// a valid/ready interface and sequences one or two bus phases per command,
// followed by an idle gap after VRAM accesses.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_reg/cmd_data are sampled only on that
// edge. cmd_ready is high only while idle. resp_valid is a one-cycle pulse
// with no backpressure; resp_data holds the last read result.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op/cmd_reg/cmd_data    op code, register index, write value
//   resp_valid/resp_data       read result pulse / held result
//   vdp_mode/read/write/wdata  VDP host bus outputs
//   vdp_rdata                  VDP read data
module vdp_host_port
   import vdp_pkg::*;
#(
   parameter int STROBE_CYCLES   = 2,
   parameter int VRAM_GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_reg,
   input  logic [7:0] cmd_data,
   output logic       resp_valid,
   output logic [7:0] resp_data,
   output logic [1:0] vdp_mode,
   output logic       vdp_read,
   output logic       vdp_write,
   output logic [7:0] vdp_wdata,
   input  logic [7:0] vdp_rdata
);

   localparam int GW = (VRAM_GAP_CYCLES > 1) ? $clog2(VRAM_GAP_CYCLES) : 1;

   host_state_e  state, state_nx;
   op_e          cmd_op_e;
   op_e          op_q;
   logic [3:0]   reg_q;
   logic [7:0]   data_q;
   logic         sel_phase_q;  // phase in flight is a select; main phase follows
   logic         sel_valid;
   logic [3:0]   sel_reg;
   logic [GW-1:0] gap_cnt;

   logic         accept, hit, need_sel;
   logic         ph_start, ph_done;
   logic [1:0]   ph_mode;
   logic [7:0]   ph_wdata;
   logic         ph_is_read;
   phase_state_e ph_state;

   assign cmd_op_e = op_e'(cmd_op);
   assign accept   = cmd_valid && cmd_ready;
   assign hit      = sel_valid && (sel_reg == cmd_reg);
   assign need_sel = op_is_reg(cmd_op_e) && !hit;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= HP_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         HP_IDLE:  if (accept) state_nx = HP_PHASE;
         HP_PHASE: if (ph_done && !sel_phase_q)
                      state_nx = op_is_reg(op_q) ? HP_IDLE : HP_GAP;
         HP_GAP:   if (gap_cnt == '0) state_nx = HP_IDLE;
         default:  state_nx = HP_IDLE;
      endcase
   end

   // Outputs: handshake and phase launch. The first phase is launched
   // straight from the command inputs on the accept edge so SETUP lands in
   // the cycle right after accept; the main phase following a select is
   // launched from the HOLD cycle using the registered command.
   always_comb begin
      cmd_ready  = (state == HP_IDLE);
      ph_start   = 1'b0;
      ph_mode    = op_mode(op_q);
      ph_wdata   = data_q;
      ph_is_read = op_q[0];
      case (state)
         HP_IDLE: begin
            if (cmd_valid) begin
               ph_start = 1'b1;
               if (need_sel) begin
                  ph_mode    = MODE_SELECT;
                  ph_wdata   = {4'b0000, cmd_reg};
                  ph_is_read = 1'b0;
               end else begin
                  ph_mode    = op_mode(cmd_op_e);
                  ph_wdata   = cmd_data;
                  ph_is_read = cmd_op_e[0];
               end
            end
         end
         HP_PHASE: if (ph_done && sel_phase_q) ph_start = 1'b1;
         default: ;
      endcase
   end

   // Command registers, select cache and gap counter
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= OP_SET_REG;
         reg_q       <= 4'h0;
         data_q      <= 8'h00;
         sel_phase_q <= 1'b0;
         sel_valid   <= 1'b0;
         sel_reg     <= 4'h0;
         gap_cnt     <= '0;
      end else begin
         if (accept) begin
            op_q        <= cmd_op_e;
            reg_q       <= cmd_reg;
            data_q      <= cmd_data;
            sel_phase_q <= need_sel;
         end
         if (state == HP_PHASE && ph_done && sel_phase_q) begin
            sel_phase_q <= 1'b0;
            sel_valid   <= 1'b1;
            sel_reg     <= reg_q;
         end
         // Loaded at every final HOLD; only used when GAP follows.
         if (state == HP_PHASE && ph_done && !sel_phase_q)
            gap_cnt <= GW'(VRAM_GAP_CYCLES - 1);
         else if (state == HP_GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
      end
   end

   vdp_bus_phase #(
      .STROBE_CYCLES (STROBE_CYCLES)
   ) u_phase (
      .clk       (clk),
      .reset     (reset),
      .start     (ph_start),
      .mode      (ph_mode),
      .wdata     (ph_wdata),
      .is_read   (ph_is_read),
      .state     (ph_state),
      .done      (ph_done),
      .rd_valid  (resp_valid),
      .rdata     (resp_data),
      .vdp_mode  (vdp_mode),
      .vdp_read  (vdp_read),
      .vdp_write (vdp_write),
      .vdp_wdata (vdp_wdata),
      .vdp_rdata (vdp_rdata)
   );

   // ph_state is kept as a named signal for probing the phase sequencer.
   phase_state_e ph_state_dbg;
   assign ph_state_dbg = ph_state;

endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: directed commands against a small VDP model,
// scoreboard of expected read results checked by an independent monitor.
module tb_vdp_host_port;
   import vdp_pkg::*;

   localparam int STROBE_CYCLES   = 2;
   localparam int VRAM_GAP_CYCLES = 16;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_reg = 4'h0;
   logic [7:0] cmd_data = 8'h00;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic [1:0] vdp_mode;
   logic       vdp_read;
   logic       vdp_write;
   logic [7:0] vdp_wdata;
   logic [7:0] vdp_rdata;

   vdp_host_port #(
      .STROBE_CYCLES   (STROBE_CYCLES),
      .VRAM_GAP_CYCLES (VRAM_GAP_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_reg    (cmd_reg),
      .cmd_data   (cmd_data),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .vdp_mode   (vdp_mode),
      .vdp_read   (vdp_read),
      .vdp_write  (vdp_write),
      .vdp_wdata  (vdp_wdata),
      .vdp_rdata  (vdp_rdata)
   );

   // ---------------- VDP model ----------------
   // Latches on the strobe falling edge using the previous cycle's mode/data.
   logic [7:0]  m_regs [0:15];
   logic [7:0]  m_vram [0:65535];
   logic [3:0]  m_sel = 4'h0;
   logic [15:0] m_waddr = 16'h0000;
   logic [15:0] m_raddr = 16'h0000;
   logic        p_wr = 1'b0, p_rd = 1'b0;
   logic [1:0]  p_mode = 2'b00;
   logic [7:0]  p_wdata = 8'h00;

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < 65536; i++) m_vram[i] = 8'h00;
   end

   assign vdp_rdata = (vdp_mode == 2'b01) ? m_regs[m_sel] : m_vram[m_raddr];

   always @(posedge clk) begin
      if (p_wr && !vdp_write) begin
         case (p_mode)
            2'b00: m_sel <= p_wdata[3:0];
            2'b01: begin
               m_regs[m_sel] <= p_wdata;
               case (m_sel)
                  4'd0: m_waddr <= {m_regs[1], p_wdata};
                  4'd1: m_waddr <= {p_wdata, m_regs[0]};
                  4'd2: m_raddr <= {m_regs[3], p_wdata};
                  4'd3: m_raddr <= {p_wdata, m_regs[2]};
                  default: ;
               endcase
            end
            2'b10: begin
               m_vram[m_waddr] <= p_wdata;
               m_waddr <= m_waddr + 16'd1;
            end
            default: ;
         endcase
      end
      if (p_rd && !vdp_read && p_mode == 2'b10) m_raddr <= m_raddr + 16'd1;
      p_wr    <= vdp_write;
      p_rd    <= vdp_read;
      p_mode  <= vdp_mode;
      p_wdata <= vdp_wdata;
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int cyc = 0;
   int wr_cyc_q[$];
   logic rv_prev = 1'b0;
   logic wr_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected queue on every resp_valid pulse.
   always @(negedge clk) begin
      if (!reset && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_unexpected: got resp_data 0x%0h, expected no response", resp_data);
         end else begin
            check("resp_data", resp_data, exp_q.pop_front());
         end
         check("resp_single_pulse", rv_prev, 0);
      end
      if (vdp_read && vdp_write) begin
         n_err++;
         $display("FAIL strobes_both_high: got read=1 write=1, expected at most one");
      end
      if (vdp_write && !wr_prev && vdp_mode == 2'b10) wr_cyc_q.push_back(cyc);
      rv_prev <= resp_valid;
      wr_prev <= vdp_write;
   end

   // ---------------- driver ----------------
   logic [1:0] log_mode  [0:31];
   logic [7:0] log_wdata [0:31];

   // Issues one command and waits for cmd_ready to return. k counts cycles
   // after the accept edge (cycle 1 = SETUP of the first phase).
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d,
                          output int k_ready, output int k_resp);
      int k;
      @(negedge clk);
      cmd_op = op; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_reg = 4'h0; cmd_data = 8'h00;
      k = 0;
      k_resp = -1;
      do begin
         @(negedge clk);
         k++;
         if (k < 32) begin
            log_mode[k]  = vdp_mode;
            log_wdata[k] = vdp_wdata;
         end
         if (resp_valid && k_resp < 0) k_resp = k;
      end while (!cmd_ready && k < 200);
      k_ready = k;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int kr, kp, kw;
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kr, kp, kw;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 8'h00);
      check("rst_vdp_mode", vdp_mode, 2'b00);
      check("rst_vdp_read", vdp_read, 0);
      check("rst_vdp_write", vdp_write, 0);
      check("rst_vdp_wdata", vdp_wdata, 8'h00);
      reset = 1'b0;

      // SET_REG 4 = 0x12, cache miss: select then reg write
      run_cmd(2'b00, 4'd4, 8'h12, kr, kp);
      check("setreg_miss_ready", kr, 9);
      check("setreg_miss_no_resp", kp, -1);
      check("sel_phase_mode", log_mode[2], 2'b00);
      check("sel_phase_wdata", log_wdata[2], 8'h04);
      check("reg_phase_mode", log_mode[6], 2'b01);
      check("reg_phase_wdata", log_wdata[6], 8'h12);
      check("model_reg4_a", m_regs[4], 8'h12);

      // SET_REG 4 = 0x34, cache hit
      run_cmd(2'b00, 4'd4, 8'h34, kr, kp);
      check("setreg_hit_ready", kr, 5);
      check("setreg_hit_mode", log_mode[2], 2'b01);
      check("setreg_hit_wdata", log_wdata[2], 8'h34);
      check("model_reg4_b", m_regs[4], 8'h34);

      // READ_REG 4, cache hit
      exp_q.push_back(8'h34);
      run_cmd(2'b01, 4'd4, 8'h00, kr, kp);
      check("readreg_hit_ready", kr, 5);
      check("readreg_hit_resp_cycle", kp, 4);

      // VRAM write address 0x0100
      run_cmd(2'b00, 4'd0, 8'h00, kr, kp);
      check("waddr_lo_ready", kr, 9);
      run_cmd(2'b00, 4'd1, 8'h01, kr, kp);
      check("waddr_hi_ready", kr, 9);

      // Three back-to-back VRAM writes
      wr_cyc_q.delete();
      for (int i = 0; i < 3; i++) begin
         run_cmd(2'b10, 4'd0, 8'hA1 + 8'(i), kr, kp);
         check("wrvram_ready", kr, 21);
      end
      check("vram_100", m_vram[16'h0100], 8'hA1);
      check("vram_101", m_vram[16'h0101], 8'hA2);
      check("vram_102", m_vram[16'h0102], 8'hA3);
      check("wr_strobe_count", wr_cyc_q.size(), 3);
      if (wr_cyc_q.size() == 3) begin
         kw = wr_cyc_q[1] - wr_cyc_q[0];
         check("wr_spacing_01", (kw >= 21) ? 1 : 0, 1);
         kw = wr_cyc_q[2] - wr_cyc_q[1];
         check("wr_spacing_12", (kw >= 21) ? 1 : 0, 1);
      end

      // Read address 0x0101, let the VDP prefetch, then two VRAM reads
      run_cmd(2'b00, 4'd2, 8'h01, kr, kp);
      run_cmd(2'b00, 4'd3, 8'h01, kr, kp);
      repeat (VRAM_GAP_CYCLES) @(negedge clk);
      exp_q.push_back(8'hA2);
      run_cmd(2'b11, 4'd0, 8'h00, kr, kp);
      check("rdvram1_ready", kr, 21);
      check("rdvram1_resp_cycle", kp, 4);
      exp_q.push_back(8'hA3);
      run_cmd(2'b11, 4'd0, 8'h00, kr, kp);
      check("rdvram2_ready", kr, 21);
      check("rdvram2_resp_cycle", kp, 4);
      check("resp_data_held", resp_data, 8'hA3);

      // Reset clears the select cache: READ_REG 6 needs a select phase
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(8'h00);
      run_cmd(2'b01, 4'd6, 8'h00, kr, kp);
      check("readreg6_ready", kr, 9);
      check("readreg6_resp_cycle", kp, 8);
      check("readreg6_sel_mode", log_mode[2], 2'b00);
      check("readreg6_sel_wdata", log_wdata[2], 8'h06);

      // Reset during a VRAM write strobe
      @(negedge clk);
      cmd_op = 2'b10; cmd_reg = 4'h0; cmd_data = 8'h77; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      kw = 0;
      do begin
         @(negedge clk);
         kw++;
      end while (!vdp_write && kw < 10);
      check("mid_saw_write", vdp_write, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_vdp_write", vdp_write, 0);
      check("mid_rst_vdp_mode", vdp_mode, 2'b00);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_resp_valid", resp_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      run_cmd(2'b00, 4'd4, 8'h56, kr, kp);
      check("post_rst_setreg_ready", kr, 9);
      check("post_rst_sel_mode", log_mode[2], 2'b00);
      check("post_rst_sel_wdata", log_wdata[2], 8'h04);
      check("model_reg4_c", m_regs[4], 8'h56);

      repeat (4) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
